// File: rtl/vga_raster_gen_pkg.sv
// Default 640x480@60 timing constants and the coordinate type for the pixel raster.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int COORD_W  = 10;
  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_raster_gen_if.sv
// Pixel-coordinate bus from the raster generator to the shape decoders.
interface vga_raster_gen_if;
  import vga_timing_pkg::*;

  logic   pix_clk;
  coord_t x;
  coord_t y;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   animate;

  modport master (output pix_clk, x, y, hsync, vsync, video_on, animate);
  modport slave  (input  pix_clk, x, y, hsync, vsync, video_on, animate);

endinterface

// File: rtl/vga_raster_gen_pix_en_div.sv
// Divides clk by CLK_DIV into a one-cycle pixel-enable strobe (CLK_DIV in 1..16).
module pix_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_range_chk
    $error("pix_en_div: CLK_DIV must be in 1..16");
  end

  logic [3:0] div_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_p0 <= '0;
      pix_en <= 1'b0;
    end else begin
      pix_en <= (div_p0 == DIV_LAST);
      div_p0 <= (div_p0 == DIV_LAST) ? 4'd0 : div_p0 + 4'd1;
    end
  end

endmodule

// File: rtl/vga_raster_gen.sv
// Raster scanner: pixel strobe, x/y counters, syncs, video_on and per-frame animate.
// Define RASTER_PIPE_ALIGN_EN to delay hsync/vsync/video_on by one pixel.
module vga_raster_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic             clk,
  input  logic             rst,
  vga_raster_gen_if.master vga
);

  localparam int     H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t X_LAST = coord_t'(H_TOT - 1);
  localparam coord_t Y_LAST = coord_t'(V_TOT - 1);
  localparam coord_t Y_ANIM = coord_t'(V_ACTIVE - 1);

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_total_chk
    $error("vga_raster_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  function automatic logic sync_n(coord_t c, int lo, int len);
    return !((int'(c) >= lo) && (int'(c) < lo + len));
  endfunction

  function automatic logic active(coord_t cx, coord_t cy);
    return (int'(cx) < H_ACTIVE) && (int'(cy) < V_ACTIVE);
  endfunction

  logic   pix_en;
  coord_t x_p0, y_p0, x_nxt, y_nxt;
  logic   hsync_p0, vsync_p0, video_on_p0, animate_p0;

  pix_en_div #(.CLK_DIV(CLK_DIV)) u_pix_en_div (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  always_comb begin
    x_nxt = x_p0;
    y_nxt = y_p0;
    if (pix_en) begin
      if (x_p0 == X_LAST) begin
        x_nxt = '0;
        y_nxt = (y_p0 == Y_LAST) ? '0 : y_p0 + coord_t'(1);
      end else begin
        x_nxt = x_p0 + coord_t'(1);
      end
    end
  end

  // Stage p0: coordinates plus syncs decoded from the next coordinate
  always_ff @(posedge clk) begin
    if (rst) begin
      x_p0        <= '0;
      y_p0        <= '0;
      hsync_p0    <= 1'b1;
      vsync_p0    <= 1'b1;
      video_on_p0 <= 1'b1;
      animate_p0  <= 1'b0;
    end else begin
      x_p0        <= x_nxt;
      y_p0        <= y_nxt;
      hsync_p0    <= sync_n(x_nxt, H_ACTIVE + H_FP, H_SYNC);
      vsync_p0    <= sync_n(y_nxt, V_ACTIVE + V_FP, V_SYNC);
      video_on_p0 <= active(x_nxt, y_nxt);
      animate_p0  <= pix_en && (x_p0 == X_LAST) && (y_p0 == Y_ANIM);
    end
  end

  assign vga.pix_clk = pix_en;
  assign vga.x       = x_p0;
  assign vga.y       = y_p0;
  assign vga.animate = animate_p0;

`ifdef RASTER_PIPE_ALIGN_EN
  logic hsync_p1, vsync_p1, video_on_p1;

  // Stage p1: one-pixel delay matching the registered RGB path
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_p1    <= 1'b1;
      vsync_p1    <= 1'b1;
      video_on_p1 <= 1'b1;
    end else if (pix_en) begin
      hsync_p1    <= hsync_p0;
      vsync_p1    <= vsync_p0;
      video_on_p1 <= video_on_p0;
    end
  end

  assign vga.hsync    = hsync_p1;
  assign vga.vsync    = vsync_p1;
  assign vga.video_on = video_on_p1;
`else
  assign vga.hsync    = hsync_p0;
  assign vga.vsync    = vsync_p0;
  assign vga.video_on = video_on_p0;
`endif

endmodule

// File: tb/tb_vga_raster_gen.sv
// Directed bench for vga_raster_gen: full-size raster at CLK_DIV 4 and 1, plus a reduced raster for frame-level checks.
module tb_vga_raster_gen;

`ifdef RASTER_PIPE_ALIGN_EN
  localparam int ALN = 1;
`else
  localparam int ALN = 0;
`endif

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  vga_raster_gen_if vga_a ();
  vga_raster_gen_if vga_b ();
  vga_raster_gen_if vga_c ();

  vga_raster_gen #(.CLK_DIV(4)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (vga_a)
  );

  vga_raster_gen #(
    .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (vga_b)
  );

  vga_raster_gen #(.CLK_DIV(1)) u_dut_c (
    .clk (clk),
    .rst (rst_c),
    .vga (vga_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected {hsync, vsync, video_on} for coordinate (x,y); aligned build uses previous pixel.
  function automatic logic [2:0] exp_sync(int x, int y, int ha, int hf, int hs, int hb,
                                          int va, int vf, int vs, int vb);
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int px = x;
    int py = y;
    if (ALN == 1) begin
      if (x == 0) begin
        px = ht - 1;
        py = (y == 0) ? vt - 1 : y - 1;
      end else begin
        px = x - 1;
      end
    end
    exp_sync[2] = !(px >= ha + hf && px < ha + hf + hs);
    exp_sync[1] = !(py >= va + vf && py < va + vf + vs);
    exp_sync[0] = (px < ha) && (py < va);
  endfunction

  function automatic logic [2:0] exp_a(int x, int y);
    return exp_sync(x, y, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [2:0] exp_b(int x, int y);
    return exp_sync(x, y, 8, 2, 3, 2, 6, 1, 2, 1);
  endfunction

  int  cx, cy, px, py, ex, ey;
  int  hs_first, hs_last, hs_cnt, vo_fall, strobes;
  int  vs_first, vs_last, vs_cnt, max_x, max_y, an_cnt, an_hit;
  bit  done;

  initial begin
    // Reset held three cycles on the full-size raster
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_rst_x", vga_a.x, 0);
    check("a_rst_y", vga_a.y, 0);
    check("a_rst_pix", vga_a.pix_clk, 0);
    check("a_rst_anim", vga_a.animate, 0);
    check("a_rst_hsync", vga_a.hsync, 1);
    check("a_rst_vsync", vga_a.vsync, 1);
    check("a_rst_video", vga_a.video_on, 1);
    rst_a = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check("a_pix_start", vga_a.pix_clk, (n % 4 == 0));
      check("a_x_start", vga_a.x, (n - 1) / 4);
    end

    // One full line: x=2 now, run until wrap to x=0
    hs_first = -1; hs_last = -1; hs_cnt = 0; vo_fall = -1; done = 0; px = 2;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (vga_a.pix_clk) begin
        cx = int'(vga_a.x);
        cy = int'(vga_a.y);
        check("a_line_x", cx, (px + 1) % 800);
        check("a_line_y", cy, (cx == 0) ? 1 : 0);
        check("a_line_sync", {vga_a.hsync, vga_a.vsync, vga_a.video_on}, exp_a(cx, cy));
        if (!vga_a.hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = cx;
          hs_last = cx;
        end
        if (!vga_a.video_on && vo_fall < 0) vo_fall = cx;
        if (cx == 0) done = 1;
        px = cx;
      end
    end
    check("a_line_wrap", done, 1);
    check("a_hsync_cnt", hs_cnt, 96);
    check("a_hsync_first", hs_first, 656 + ALN);
    check("a_hsync_last", hs_last, 751 + ALN);
    check("a_video_fall", vo_fall, 640 + ALN);

    // Reduced raster (15x10): one full frame
    @(negedge clk);
    rst_b = 1'b0;
    strobes = 0; done = 0; px = 14; py = 9;
    vs_first = -1; vs_last = -1; vs_cnt = 0; max_x = 0; max_y = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      cx = int'(vga_b.x);
      cy = int'(vga_b.y);
      if (vga_b.pix_clk) begin
        strobes++;
        ex = (px == 14) ? 0 : px + 1;
        ey = (px == 14) ? ((py == 9) ? 0 : py + 1) : py;
        check("b_frame_x", cx, ex);
        check("b_frame_y", cy, ey);
        if (strobes > 1)
          check("b_frame_sync", {vga_b.hsync, vga_b.vsync, vga_b.video_on}, exp_b(cx, cy));
        if (!vga_b.vsync) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = cy;
          vs_last = cy;
        end
        if (cx > max_x) max_x = cx;
        if (cy > max_y) max_y = cy;
        px = cx;
        py = cy;
      end else if (strobes > 0 && cx == 0 && cy == 0) begin
        done = 1;
      end
    end
    check("b_frame_wrap", done, 1);
    check("b_frame_strobes", strobes, 150);
    check("b_wrap_sync", {vga_b.hsync, vga_b.vsync, vga_b.video_on}, exp_b(0, 0));
    check("b_vsync_cnt", vs_cnt, 30);
    check("b_vsync_first", vs_first, 7);
    check("b_vsync_last", vs_last, 8 + ALN);
    check("b_max_x", max_x, 14);
    check("b_max_y", max_y, 9);

    // Three frames of animate pulses
    an_cnt = 0; an_hit = 0;
    for (int i = 0; i < 1800; i++) begin
      @(negedge clk);
      if (vga_b.animate) begin
        an_cnt++;
        if (vga_b.x == 10'd0 && vga_b.y == 10'd6) an_hit++;
      end
    end
    check("b_anim_cnt", an_cnt, 3);
    check("b_anim_at_0_6", an_hit, 3);

    // Mid-frame reset at (11,7) with divider phase 2
    done = 0;
    for (int i = 0; i < 700 && !done; i++) begin
      @(negedge clk);
      if (vga_b.x == 10'd11 && vga_b.y == 10'd7) done = 1;
    end
    check("b_find_11_7", done, 1);
    check("b_pre_rst_sync", {vga_b.hsync, vga_b.vsync, vga_b.video_on}, 0);
    check("b_pre_rst_pix", vga_b.pix_clk, 0);
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("b_mid_rst_x", vga_b.x, 0);
    check("b_mid_rst_y", vga_b.y, 0);
    check("b_mid_rst_pix", vga_b.pix_clk, 0);
    check("b_mid_rst_anim", vga_b.animate, 0);
    check("b_mid_rst_hsync", vga_b.hsync, 1);
    check("b_mid_rst_vsync", vga_b.vsync, 1);
    check("b_mid_rst_video", vga_b.video_on, 1);
    rst_b = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check("b_pix_restart", vga_b.pix_clk, (n == 4));
      check("b_x_restart", vga_b.x, (n == 5) ? 1 : 0);
    end

    // CLK_DIV=1: strobe every cycle, one line of hsync
    rst_c = 1'b0;
    hs_first = -1; hs_last = -1; hs_cnt = 0; done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      check("c_pix_const", vga_c.pix_clk, 1);
      if (vga_c.y == 10'd1) begin
        done = 1;
      end else if (!vga_c.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(vga_c.x);
        hs_last = int'(vga_c.x);
      end
    end
    check("c_line_wrap", done, 1);
    check("c_hsync_cnt", hs_cnt, 96);
    check("c_hsync_first", hs_first, 656 + ALN);
    check("c_hsync_last", hs_last, 751 + ALN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_raster_gen.md
Name: vga_raster_gen

Overview:
Source side of the pixel-coordinate interface consumed by the arrow/target shape decoders. Divides the system clock into a pixel-enable strobe and scans a 640x480@60 raster. Drives x, y, pix_clk, sync, video_on, and a once-per-frame animate strobe. Instantiated once in the top level; its x/y fan out to every shape module.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
pix_clk  out  1  pixel-enable strobe, high one clk cycle in every CLK_DIV
x  out  10  horizontal pixel counter, 0..H_TOTAL-1
y  out  10  vertical line counter, 0..V_TOTAL-1
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
video_on  out  1  high when x<H_ACTIVE and y<V_ACTIVE
animate  out  1  one-clk frame strobe for object motion

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both totals must be <=1024; the design rejects larger values at elaboration.
- Reset, on a clk edge with rst=1: divider=0, x=0, y=0, pix_clk=0, animate=0, hsync=1, vsync=1, video_on=1.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_clk is registered high on the cycle in which the divider equals CLK_DIV-1.
  - For CLK_DIV=1, pix_clk stays high every cycle after reset.
  - First pix_clk after reset release occurs CLK_DIV cycles after the first non-reset edge.
- Counter advance, on each clk edge where pix_clk=1:
  - x increments.
  - When x=H_TOTAL-1: x goes to 0 and y increments.
  - When (x,y)=(H_TOTAL-1,V_TOTAL-1): both go to 0.
  - x, y never take values >= H_TOTAL / V_TOTAL.
- hsync, vsync and video_on are registered. They are computed from the next x/y, so they change on the same edge as x/y and are always consistent with the presented coordinate.
  - hsync=0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync=0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
- animate:
  - High for exactly one clk cycle, on the edge where (x,y) advances from (H_TOTAL-1, V_ACTIVE-1) to (0, V_ACTIVE), i.e. the start of vertical blanking.
  - Occurs exactly once per frame.
- Reset asserted mid-frame: all state returns to reset values on that edge regardless of divider phase. No partial line or sync pulse is completed.
- Outputs hold their values between pix_clk strobes.

Optional Feature:
Macro RASTER_PIPE_ALIGN_EN.
- Defined: hsync, vsync and video_on are delayed by one extra pixel (one pix_clk strobe), to align with a one-stage registered RGB path after the shape decoders. x, y, pix_clk and animate are unchanged. Reset value of the delay stage is hsync=1, vsync=1, video_on=1.
- Undefined: timing exactly as in Behaviour.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants: H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP;
  - derived totals H_TOTAL and V_TOTAL;
  - the 10-bit coordinate type.
- One sub-module, pix_en_div: CLK_DIV divider producing the pix_clk strobe. It is reused by any block that needs pixel-rate enables.

Test Plan:
1. Reset held 3 cycles then released, CLK_DIV=4 -> pix_clk first high on the 4th cycle after release, then every 4 cycles; x=1 on the edge following the first strobe.
2. Run one line -> hsync low exactly when x=656..751 (96 strobes); video_on falls at x=640; x wraps 799->0 and y increments 0->1 on the same edge.
3. Run one full frame -> vsync low for y=490..491 only; (799,524) wraps to (0,0); exactly 420000 strobes per frame.
4. Count animate over 3 frames -> exactly 3 one-cycle pulses, each coincident with (x,y) becoming (0,480).
5. Assert rst for one cycle at (x,y)=(300,200) with divider=2 -> next cycle x=0, y=0, pix_clk=0, animate=0, hsync=1, vsync=1, video_on=1.
6. CLK_DIV=1 with RASTER_PIPE_ALIGN_EN defined -> pix_clk constant 1; hsync low for x=657..752.
